fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx.sv | 146 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a registered-read byte FIFO onto an async serial line.
// Optional even parity bit when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              empty,
    output logic              rd,
    input  logic [DATA_W-1:0] dataout,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] BAUD_PRE  = 16'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state;
    logic [15:0]       baud;
    logic [BW-1:0]     bitcnt;
    logic [DATA_W-1:0] shift;
    logic              baud_end;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              par;
`endif

    assign baud_end = (baud == BAUD_LAST);

    // Frame sequencer: pops one byte, then walks start/data/stop with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tx         <= 1'b1;
            rd         <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            baud       <= 16'd0;
            bitcnt     <= '0;
            shift      <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            rd         <= 1'b0;
            frame_done <= 1'b0;
            baud       <= baud + 16'd1;
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    baud <= 16'd0;
                    if (!empty) begin
                        state <= POP;
                        rd    <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                POP: begin
                    state <= LOAD;
                    baud  <= 16'd0;
                end
                LOAD: begin
                    shift <= dataout;
`ifdef FIFO_UART_TX_PARITY_EN
                    par   <= ^dataout;
`endif
                    state <= START;
                    tx    <= 1'b0;
                    baud  <= 16'd0;
                end
                START: begin
                    if (baud_end) begin
                        state <= DATA;
                        tx    <= shift[0];
                        baud  <= 16'd0;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud  <= 16'd0;
                        shift <= shift >> 1;
                        if (bitcnt == BIT_LAST) begin
                            bitcnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                            state  <= PARITY;
                            tx     <= par;
`else
                            state  <= STOP;
                            tx     <= 1'b1;
`endif
                        end else begin
                            bitcnt <= bitcnt + BW'(1);
                            tx     <= shift[1];
                        end
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_end) begin
                        state <= STOP;
                        tx    <= 1'b1;
                        baud  <= 16'd0;
                    end
                end
`endif
                STOP: begin
                    frame_done <= (baud == BAUD_PRE);
                    if (baud_end) begin
                        baud       <= 16'd0;
                        frame_done <= 1'b0;
                        if (!empty) begin
                            state <= POP;
                            rd    <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    baud  <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: random byte streams through a FIFO model, line checked
// cycle by cycle against frames built from the byte values.
module tb_fifo_uart_tx;

    localparam int DW = 8;
    localparam int C  = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = DW + 2 + PAR;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          empty;
    logic          rd;
    logic [DW-1:0] dataout = '0;
    logic          tx;
    logic          busy;
    logic          frame_done;

    logic [7:0] mem [0:255];
    int         pushed = 0;
    int         popped = 0;
    int         rd_cnt = 0;
    int         underflow = 0;
    logic       glitch = 1'b0;
    logic [7:0] exp_q [$];

    int n_checks = 0;
    int n_errors = 0;

    fifo_uart_tx #(.DATA_W(DW), .CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .reset      (reset),
        .empty      (empty),
        .rd         (rd),
        .dataout    (dataout),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    assign empty = (pushed == popped) ? !glitch : 1'b0;

    // FIFO model: registered read, garbage on dataout when not reading
    always @(posedge clk) begin
        if (rd) begin
            if (pushed == popped) begin
                underflow <= underflow + 1;
            end else begin
                dataout <= mem[popped[7:0]];
                popped  <= popped + 1;
            end
        end else begin
            dataout <= DW'($urandom);
        end
    end

    always @(negedge clk) begin
        if (rd) rd_cnt <= rd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[pushed[7:0]] = b;
        pushed++;
        exp_q.push_back(b);
    endtask

    task automatic wait_rd(output int w, output bit ok);
        w = 0;
        while (!rd && w < 60) begin
            @(negedge clk);
            w++;
        end
        ok = rd;
        if (!ok) check("rd_timeout", 32'd0, 32'd1);
    endtask

    // exp_w < 0: any wait before the pop is accepted
    task automatic expect_frame(input int exp_w, input bit glitchy);
        logic [7:0] b;
        int w;
        bit ok;
        int k;
        logic e;
        if (exp_q.size() == 0) begin
            check("model_empty", 32'd1, 32'd0);
            return;
        end
        b = exp_q.pop_front();
        wait_rd(w, ok);
        if (!ok) return;
        if (exp_w >= 0) check("pop_wait", w, exp_w);
        check("pop_busy", busy, 1);
        check("pop_tx", tx, 1);
        @(negedge clk);
        check("load_rd", rd, 0);
        check("load_tx", tx, 1);
        check("load_busy", busy, 1);
        for (int i = 0; i < NB * C; i++) begin
            @(negedge clk);
            k = i / C;
            if (k == 0) e = 1'b0;
            else if (k <= DW) e = b[k-1];
            else if (PAR != 0 && k == DW + 1) e = ^b;
            else e = 1'b1;
            glitch = (glitchy && k >= 1 && k <= DW) ? 1'($urandom) : 1'b0;
            check("tx", tx, e);
            check("frame_done", frame_done, (i == NB * C - 1));
            check("busy", busy, 1);
            check("rd_mid", rd, 0);
        end
        glitch = 1'b0;
    endtask

    task automatic expect_idle();
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_tx", tx, 1);
        check("idle_rd", rd, 0);
    endtask

    initial begin
        int n;
        int w;
        bit ok;
        push(8'h05);
        repeat (3) begin
            @(negedge clk);
            check("rst_tx", tx, 1);
            check("rst_rd", rd, 0);
            check("rst_busy", busy, 0);
            check("rst_fd", frame_done, 0);
        end
        reset = 1'b0;
        expect_frame(1, 1'b0);
        expect_idle();

        for (int i = 0; i < 8; i++) push((i == 0) ? 8'd5 : 8'(10 * i));
        expect_frame(-1, 1'b0);
        for (int i = 1; i < 8; i++) expect_frame(1, 1'b0);
        expect_idle();
        check("burst_pops", rd_cnt, 9);

        push(8'h5A);
        expect_frame(-1, 1'b1);
        expect_idle();
        check("glitch_pops", rd_cnt, 10);

        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) push(8'($urandom));
            expect_frame(-1, 1'b0);
            for (int j = 1; j < n; j++) expect_frame(1, 1'b0);
            expect_idle();
        end

        push(8'h90);
        push(8'h33);
        wait_rd(w, ok);
        repeat (2 + C + 3 * C) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rd", rd, 0);
        reset = 1'b0;
        void'(exp_q.pop_front());
        expect_frame(1, 1'b0);
        expect_idle();

`ifdef FIFO_UART_TX_PARITY_EN
        push(8'h07);
        push(8'h03);
        expect_frame(-1, 1'b0);
        expect_frame(1, 1'b0);
        expect_idle();
`endif

        repeat (4) @(negedge clk);
        check("all_popped", popped, pushed);
        check("rd_total", rd_cnt, pushed);
        check("underflow", underflow, 0);
        check("model_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
